// File: rtl/vedic_pkg.sv
// Shared widths, types and the small Vedic (Urdhva-Tiryagbhyam) multiply cells
// used to build the 16x16 partial-product multipliers.
package vedic_pkg;

  localparam int OPW     = 32;
  localparam int PRODW   = 64;
  localparam int HALFW   = 16;
  localparam int LATENCY = 3;

  typedef logic [OPW-1:0]   operand_t;
  typedef logic [PRODW-1:0] product_t;
  typedef logic [HALFW-1:0] half_t;
  typedef logic [OPW-1:0]   pp_t;

  // 2x2 cell: vertical and crosswise products with a single carry ripple.
  function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
    logic t1, t2, t3, c;
    t1 = x[1] & y[0];
    t2 = x[0] & y[1];
    t3 = x[1] & y[1];
    c  = t1 & t2;
    return {t3 & c, t3 ^ c, t1 ^ t2, x[0] & y[0]};
  endfunction

  // 4x4 from four 2x2 quadrants; the middle sum keeps its carry bit.
  function automatic logic [7:0] vedic4x4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] q0, q1, q2, q3;
    logic [4:0] mid;
    q0  = vedic2x2(x[1:0], y[1:0]);
    q1  = vedic2x2(x[3:2], y[1:0]);
    q2  = vedic2x2(x[1:0], y[3:2]);
    q3  = vedic2x2(x[3:2], y[3:2]);
    mid = {1'b0, q1} + {1'b0, q2};
    return {4'b0, q0} + {1'b0, mid, 2'b0} + {q3, 4'b0};
  endfunction

  // 8x8 from four 4x4 quadrants, same combine one level up.
  function automatic logic [15:0] vedic8x8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] q0, q1, q2, q3;
    logic [8:0] mid;
    q0  = vedic4x4(x[3:0], y[3:0]);
    q1  = vedic4x4(x[7:4], y[3:0]);
    q2  = vedic4x4(x[3:0], y[7:4]);
    q3  = vedic4x4(x[7:4], y[7:4]);
    mid = {1'b0, q1} + {1'b0, q2};
    return {8'b0, q0} + {3'b0, mid, 4'b0} + {q3, 8'b0};
  endfunction

endpackage

// File: rtl/vedic32x32_vedic16x16.sv
// Combinational 16x16 -> 32 Vedic multiplier built from four 8x8 quadrants.
module vedic16x16
  import vedic_pkg::*;
(
  input  half_t a_i,
  input  half_t b_i,
  output pp_t   p_o
);

  logic [15:0] quad_d [4];
  logic [16:0] mid_d;

  // Quadrant gi pairs a half (gi%2) with b half (gi/2): 0=lo*lo, 1=hi*lo, 2=lo*hi, 3=hi*hi.
  for (genvar gi = 0; gi < 4; gi++) begin : g_quad
    assign quad_d[gi] = vedic8x8(a_i[(gi % 2) * 8 +: 8], b_i[(gi / 2) * 8 +: 8]);
  end

  assign mid_d = {1'b0, quad_d[1]} + {1'b0, quad_d[2]};
  assign p_o   = {16'b0, quad_d[0]} + {7'b0, mid_d, 8'b0} + {quad_d[3], 16'b0};

endmodule

// File: rtl/vedic32x32.sv
// Three-stage pipelined unsigned 32x32 -> 64 Vedic multiplier with a fill indicator.
module vedic32x32
  import vedic_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  operand_t a,
  input  operand_t b,
  output product_t result,
  output logic     valid_out
);

  operand_t           a_q, b_q;
  pp_t                pp_d [4];
  pp_t                pp_q [4];
  logic [OPW:0]       mid_d;
  product_t           result_d, result_q;
  logic [LATENCY-1:0] vld_q, vld_d;

  // Stage 1: capture the operand pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Stage 2: four 16x16 partial products, one register per quadrant.
  for (genvar gi = 0; gi < 4; gi++) begin : g_pp
    vedic16x16 u_mul (
      .a_i (a_q[(gi % 2) * HALFW +: HALFW]),
      .b_i (b_q[(gi / 2) * HALFW +: HALFW]),
      .p_o (pp_d[gi])
    );

    // Register this quadrant's partial product.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) pp_q[gi] <= '0;
      else      pp_q[gi] <= pp_d[gi];
    end
  end

  // Final combine: cross terms summed at 33 bits so their carry reaches bit 48.
  always_comb begin
    mid_d    = {1'b0, pp_q[1]} + {1'b0, pp_q[2]};
    result_d = {32'b0, pp_q[0]} + {15'b0, mid_d, 16'b0} + {pp_q[3], 32'b0};
  end

  // Stage 3: register the full product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) result_q <= '0;
    else      result_q <= result_d;
  end

  // Fill indicator is independent of operand data, so unknown inputs cannot reach it.
  assign vld_d = {vld_q[LATENCY-2:0], 1'b1};

  // Shift ones in after reset release; the MSB rises once every stage holds real data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_q <= '0;
    else      vld_q <= vld_d;
  end

  assign result    = result_q;
  assign valid_out = vld_q[LATENCY-1];

endmodule

// File: tb/tb_vedic32x32.sv
// Self-checking bench: random and directed operands against a queue-based a*b model.
module tb_vedic32x32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [63:0] result;
  logic        valid_out;

  int n_checks = 0;
  int n_errors = 0;

  // Model: products in flight, preloaded with the zeros the cleared pipeline emits.
  logic [63:0] exp_q[$];
  int          edges_since_rel = 0;

  always #5 clk = ~clk;

  vedic32x32 dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .result    (result),
    .valid_out (valid_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000 | $urandom;
      default: return $urandom;
    endcase
  endfunction

  // Apply one operand pair, clock it in, then compare result and valid_out.
  task automatic step(input logic [31:0] av, input logic [31:0] bv, input string tag,
                      input bit verbose);
    logic [63:0] e;
    logic [63:0] ev;
    a = av;
    b = bv;
    @(posedge clk);
    if (rst) begin
      exp_q.push_back(64'(av) * 64'(bv));
      edges_since_rel++;
    end
    #1;
    e  = rst ? exp_q.pop_front() : 64'd0;
    ev = (rst && edges_since_rel >= 3) ? 64'd1 : 64'd0;
    check({tag, " result"}, result, e);
    check({tag, " valid"}, {63'b0, valid_out}, ev);
    if (verbose)
      $display("txn %-8s a=%h b=%h result=%h valid=%0d", tag, av, bv, result, valid_out);
  endtask

  task automatic release_rst();
    rst = 1'b1;
    exp_q = {};
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd0);
    edges_since_rel = 0;
  endtask

  logic [31:0] ca [6] = '{32'h0000_0000, 32'h0000_0003, 32'h8000_0000,
                          32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_FFFF};
  logic [31:0] cb [6] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0002,
                          32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_0000};

  initial begin
    rst = 1'b0;
    a   = '0;
    b   = '0;
    #1;
    check("async_rst result", result, 64'd0);
    check("async_rst valid", {63'b0, valid_out}, 64'd0);

    // Hold reset for 5 cycles with garbage inputs.
    for (int i = 0; i < 5; i++) step(rnd_op(), rnd_op(), "inrst", 1'b1);

    release_rst();

    // Corners, max operands, then drain so each emerges while observed.
    for (int i = 0; i < 6; i++) step(ca[i], cb[i], "corner", 1'b1);
    for (int i = 0; i < 4; i++) step(32'h1234_5678, 32'h9ABC_DEF0, "hold", 1'b1);

    // Back-to-back stream.
    for (int i = 0; i < 1000; i++) step(rnd_op(), rnd_op(), "stream", 1'b0);
    $display("txn stream   1000 pairs done");

    // Pull reset low between edges; outputs must clear without a clock.
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst result", result, 64'd0);
    check("mid_rst valid", {63'b0, valid_out}, 64'd0);
    $display("txn midrst   result=%h valid=%0d", result, valid_out);
    for (int i = 0; i < 2; i++) step(rnd_op(), rnd_op(), "inrst2", 1'b1);
    release_rst();
    for (int i = 0; i < 5; i++) step(rnd_op(), rnd_op(), "refill", 1'b1);

    // Random regression.
    for (int i = 0; i < 10000; i++) step($urandom, $urandom, "regress", 1'b0);
    $display("txn regress  10000 pairs done");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
